// File: rtl/dram_rd_prefetch.sv
// Burst read prefetcher: turns one (address, length) request into back-to-back single-word
// DRAM reads and buffers returned words in a small FIFO drained over a valid/ready stream.
// Reads are only issued while FIFO space is guaranteed for every outstanding return.
module dram_rd_prefetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned LEN_WIDTH  = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  srstn,
  // Burst request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  // DRAM read port
  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] dram_addr_rd,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] dram_data_rd,
  // Consumer stream
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  // Status
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic [LEN_WIDTH-1:0]  popped_q, popped_d;
  logic [CntW-1:0]       outst_q, outst_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic          accept, issue, push, pop, stray, credit, last_head;
  logic [CntW:0] occupancy;

  // Credit: buffered words plus reads still in flight must leave room for one more
  assign occupancy = {1'b0, count_q} + {1'b0, outst_q};
  assign credit    = occupancy < DepthC;

  assign req_ready = (state_q == StIdle) && !done_q;
  assign accept    = req_valid && req_ready;
  assign issue     = (state_q == StIssue) && credit;
  // A return with nothing outstanding is not ours (e.g. in flight across a reset)
  assign push      = dram_valid && (outst_q != '0);
  assign stray     = dram_valid && (outst_q == '0);
  assign out_valid = count_q != '0;
  assign pop       = out_valid && out_ready;
  assign last_head = popped_q == (len_q - LEN_WIDTH'(1));

  assign dram_en_rd   = issue;
  assign dram_addr_rd = issue ? addr_q : '0;
  assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last     = out_valid && last_head;
  // done_q covers the pulse cycle, which is still part of the busy window
  assign busy         = (state_q != StIdle) || done_q;
  assign done         = done_q;
  assign err          = err_q;

  // Burst sequencing: accept, issue one word per credited cycle, wait for the final pop
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d   = req_addr;
          len_d    = req_len;
          remain_d = req_len;
          if (req_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && last_head) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy counters, popped-word index and sticky error
  always_comb begin
    outst_d  = outst_q;
    count_d  = count_q;
    popped_d = popped_q;
    err_d    = err_q | stray;
    if (issue && !push) begin
      outst_d = outst_q + CntW'(1);
    end else if (!issue && push) begin
      outst_d = outst_q - CntW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
    if (accept) begin
      popped_d = '0;
    end else if (pop) begin
      popped_d = popped_q + LEN_WIDTH'(1);
    end
  end

  // Control and counter state
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= '0;
      remain_q <= '0;
      popped_q <= '0;
      outst_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      remain_q <= remain_d;
      popped_q <= popped_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // FIFO storage; no reset needed since out_data is masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dram_data_rd;
    end
  end

endmodule

// File: tb/tb_dram_rd_prefetch.sv
// Bench for dram_rd_prefetch: table of bursts plus hand-written stall and reset sequences.
// Inputs are driven and outputs observed once per cycle at the falling edge.
module tb_dram_rd_prefetch;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam int LW = 10;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          srstn;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          dram_en_rd;
  logic [AW-1:0] dram_addr_rd;
  logic          dram_valid;
  logic [DW-1:0] dram_data_rd;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          busy, done, err;

  dram_rd_prefetch #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk         (clk),
    .srstn       (srstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .dram_en_rd  (dram_en_rd),
    .dram_addr_rd(dram_addr_rd),
    .dram_valid  (dram_valid),
    .dram_data_rd(dram_data_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            lat;
    int            mode;      // 0: out_ready=1, 1: toggling, 2: out_ready=0
    logic [AW-1:0] exp_last;  // address of the final read
    int            done_off;  // accept-to-done cycles, -1: check against last pop instead
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;
  int rdy_mode = 0;
  bit pend_req = 1'b0;

  int            dq_due[$];
  logic [AW-1:0] dq_addr[$];
  logic [AW-1:0] rd_addr[$];
  logic [DW-1:0] pop_data[$];
  bit            pop_last[$];
  int n_rd, n_pop, n_done, acc_cyc, first_rd_cyc, done_cyc, last_pop_cyc, max_occ;
  bit rdy_at_done, busy_at_done, busy_post_acc, rdy_after, saw_valid;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[13:0] ^ 14'h2A5C, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr.delete();
    pop_data.delete();
    pop_last.delete();
    n_rd = 0; n_pop = 0; n_done = 0; max_occ = 0;
    acc_cyc = -100; first_rd_cyc = -1; done_cyc = -1; last_pop_cyc = -1;
    rdy_at_done = 1'b1; busy_at_done = 1'b0; busy_post_acc = 1'b0;
    rdy_after = 1'b0; saw_valid = 1'b0;
  endtask

  // One cycle: drive this cycle's inputs, then log what the DUT shows
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (dq_due.size() != 0 && dq_due[0] == cyc) begin
      dram_valid   = 1'b1;
      dram_data_rd = mem_word(dq_addr[0]);
      void'(dq_due.pop_front());
      void'(dq_addr.pop_front());
    end else begin
      dram_valid   = 1'b0;
      dram_data_rd = '0;
    end
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 2) == 1;
      default: out_ready = 1'b0;
    endcase
    req_valid = pend_req;
    if (n_rd - n_pop > max_occ) max_occ = n_rd - n_pop;
    if (out_valid) saw_valid = 1'b1;
    if (cyc == acc_cyc + 1) busy_post_acc = busy;
    if (dram_en_rd) begin
      n_rd++;
      rd_addr.push_back(dram_addr_rd);
      dq_due.push_back(cyc + lat);
      dq_addr.push_back(dram_addr_rd);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      n_pop++;
      pop_data.push_back(out_data);
      pop_last.push_back(out_last);
      last_pop_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc     = cyc;
      rdy_at_done  = req_ready;
      busy_at_done = busy;
    end
    if (req_valid && req_ready) begin
      acc_cyc  = cyc;
      pend_req = 1'b0;
    end
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [LW-1:0] l, input int lt,
                       input int md);
    clear_logs();
    lat      = lt;
    rdy_mode = md;
    req_addr = a;
    req_len  = l;
    pend_req = 1'b1;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    chk({name, " done_seen"}, n_done != 0, 1);
    tick();
    rdy_after = req_ready;
  endtask

  task automatic check_burst(input string name, input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic [AW-1:0] exp_last, input int done_off);
    logic [AW-1:0] ea;
    chk({name, " n_reads"}, n_rd, l);
    for (int i = 0; i < rd_addr.size(); i++) begin
      ea = a + AW'(i);
      chk($sformatf("%s rd_addr[%0d]", name, i), rd_addr[i], ea);
    end
    if (l != 0 && rd_addr.size() != 0) begin
      chk({name, " final_addr"}, rd_addr[rd_addr.size()-1], exp_last);
      chk({name, " first_rd_lat"}, first_rd_cyc - acc_cyc, 1);
    end
    chk({name, " n_pops"}, n_pop, l);
    for (int i = 0; i < pop_data.size(); i++) begin
      ea = a + AW'(i);
      chk($sformatf("%s data[%0d]", name, i), pop_data[i], mem_word(ea));
      chk($sformatf("%s last[%0d]", name, i), pop_last[i], i == int'(l) - 1);
    end
    chk({name, " done_count"}, n_done, 1);
    if (done_off >= 0) chk({name, " done_time"}, done_cyc - acc_cyc, done_off);
    else               chk({name, " done_after_pop"}, done_cyc - last_pop_cyc, 1);
    chk({name, " ready_at_done"}, rdy_at_done, 0);
    chk({name, " ready_after_done"}, rdy_after, 1);
    chk({name, " busy_at_done"}, busy_at_done, 1);
    chk({name, " busy_after_accept"}, busy_post_acc, 1);
    chk({name, " occupancy_le_depth"}, max_occ <= FD, 1);
    chk({name, " saw_valid"}, saw_valid, l != 0);
    chk({name, " err"}, err, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req_ready"}, req_ready, 1);
    chk({tag, " dram_en_rd"}, dram_en_rd, 0);
    chk({tag, " dram_addr_rd"}, dram_addr_rd, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err, 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{18'h00100, 10'd4,  1, 0, 18'h00103, 7};
    vecs[1] = '{18'h3FFFE, 10'd4,  1, 0, 18'h00001, 7};
    vecs[2] = '{18'h01234, 10'd0,  1, 0, 18'h00000, 1};
    vecs[3] = '{18'h02000, 10'd16, 2, 1, 18'h0200F, -1};
    vecs[4] = '{18'h00055, 10'd9,  2, 0, 18'h0005D, 13};

    srstn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    dram_valid = 1'b0; dram_data_rd = '0; out_ready = 1'b0;
    #2 chk_reset("por");
    @(negedge clk);
    srstn = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      start(vecs[v].addr, vecs[v].len, vecs[v].lat, vecs[v].mode);
      run_until_done($sformatf("vec%0d", v), 200);
      check_burst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].exp_last,
                  vecs[v].done_off);
    end

    // Consumer stalled: issue must stop once reads in flight plus buffered words fill the FIFO
    start(18'h04000, 10'd20, 3, 2);
    repeat (30) tick();
    chk("stall n_reads", n_rd, 8);
    chk("stall n_pops", n_pop, 0);
    chk("stall out_valid", out_valid, 1);
    rdy_mode = 0;
    run_until_done("stall", 300);
    check_burst("stall", 18'h04000, 10'd20, 18'h04013, -1);

    // Reset with three reads in flight; their late returns must be flagged and dropped
    start(18'h07000, 10'd10, 3, 0);
    for (int k = 0; k < 10 && n_rd < 3; k++) tick();
    chk("rst inflight_reads", n_rd, 3);
    #1 srstn = 1'b0;
    #1 chk_reset("midrst");
    tick();
    srstn = 1'b1;
    saw_valid = 1'b0;
    repeat (4) tick();
    chk("rst late_err", err, 1);
    chk("rst no_out_valid", saw_valid, 0);
    chk("rst no_new_reads", n_rd, 3);
    chk("rst ready", req_ready, 1);
    chk("rst busy", busy, 0);
    repeat (2) tick();
    chk("rst err_sticky", err, 1);
    #1 srstn = 1'b0;
    #1 chk("rst err_cleared", err, 0);
    @(negedge clk);
    srstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
